// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Carry is registered between chunks; carry/overflow flags captured on the last chunk.
module adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             is_overflowed
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] acc_next;
    logic             cin_msb;

    // Operands shift right each step, so the active chunk is always the low slice.
    assign part = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
    assign cin_msb = part[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    if (CHUNK == WIDTH) begin : g_one
        assign acc_next = part[CHUNK-1:0];
    end else begin : g_multi
        assign acc_next = {part[CHUNK-1:0], acc_q[WIDTH-1:CHUNK]};
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = inA;
                    b_d     = sub ? ~inB : inB;
                    carry_d = sub;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = acc_next;
                carry_d = part[CHUNK];
                k_d     = k_q + 1'b1;
                if (k_q == KLAST) begin
                    sum_d   = acc_next;
                    cout_d  = part[CHUNK];
                    ovf_d   = cin_msb ^ part[CHUNK];
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = (state_q == DONE) && !rst;
    assign sum           = sum_q;
    assign cout          = cout_q;
    assign is_overflowed = ovf_q;
endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: 16/4 directed+random, plus 4-bit sweeps
// at CHUNK=1,2,4 over all operand pairs in both modes.
module tb_adder_seq;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int sw_done = 0;
    bit main_done = 1'b0;

    // Plain arithmetic reference: modulo sum, unsigned carry/no-borrow, signed range overflow.
    function automatic exp_t mk(int w, int a, int b, bit s, int t);
        exp_t e;
        int m, sa, sb, sr, res;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (s) begin
            res = a - b;
            e.c = (a >= b);
            sr  = sa - sb;
        end else begin
            res = a + b;
            e.c = (a + b >= m);
            sr  = sa + sb;
        end
        e.v = (sr >= m / 2) || (sr < -(m / 2));
        res = ((res % m) + m) % m;
        e.s = 16'(res);
        e.t = t;
        return e;
    endfunction

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        is_overflowed;

    adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .is_overflowed(is_overflowed)
    );

    int or_mode = 0;
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    exp_t q[$];
    exp_t me;
    bit seen = 1'b0;
    logic [17:0] cap;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL overlap in_ready=%b required 0", in_ready);
            end
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out sum=%h required no output", sum);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    cap = {sum, cout, is_overflowed};
                    if (cyc - q[0].t != 5) begin
                        failures++;
                        $display("FAIL latency got=%0d required 5", cyc - q[0].t);
                    end
                end else if ({sum, cout, is_overflowed} !== cap) begin
                    failures++;
                    $display("FAIL stable got=%h required %h",
                             {sum, cout, is_overflowed}, cap);
                end
                if (out_ready) begin
                    me = q.pop_front();
                    seen = 1'b0;
                    checks++;
                    if (sum !== me.s || cout !== me.c || is_overflowed !== me.v) begin
                        failures++;
                        $display("FAIL result sum=%h cout=%b ovf=%b required %h %b %b",
                                 sum, cout, is_overflowed, me.s, me.c, me.v);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required %h", nm, act, req);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        inA = a;
        inB = b;
        sub = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end else begin
            q.push_back(mk(16, int'(a), int'(b), s, cyc));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        inA = 16'($urandom);
        inB = 16'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b1;
        inA = 16'hFFFF;
        inB = 16'h0001;
        sub = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        issue(16'h7FFF, 16'h0001, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        issue(16'h0003, 16'h0005, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1);
        drain();

        @(negedge clk);
        or_mode = 2;
        issue(16'h1111, 16'h2222, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        inA = 16'hAAAA;
        inB = 16'h5555;
        sub = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        or_mode = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        issue(16'hAAAA, 16'h5555, 1'b1);
        drain();

        issue(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_out", 32'(out_valid), 32'd0);
        end
        issue(16'h1234, 16'h4321, 1'b0);
        drain();

        @(negedge clk);
        or_mode = 1;
        repeat (40) issue(16'($urandom), 16'($urandom), 1'($urandom));
        @(negedge clk);
        or_mode = 0;
        drain();
        main_done = 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int C = 1 << g;
        localparam int ST = 4 / C;

        logic       sr;
        logic       siv;
        logic       sir;
        logic [3:0] sa;
        logic [3:0] sb;
        logic       ssub;
        logic       sov;
        logic       sordy;
        logic [3:0] ssum;
        logic       sco;
        logic       svf;

        adder_seq #(.WIDTH(4), .CHUNK(C)) dut (
            .clk(clk), .rst(sr),
            .in_valid(siv), .in_ready(sir),
            .inA(sa), .inB(sb), .sub(ssub),
            .out_valid(sov), .out_ready(sordy),
            .sum(ssum), .cout(sco), .is_overflowed(svf)
        );

        always @(posedge clk) begin
            #1;
            sordy = ($urandom_range(0, 3) != 0);
        end

        exp_t sq[$];
        exp_t se;
        bit sseen = 1'b0;

        always @(negedge clk) begin
            if (!sr && sov) begin
                checks++;
                if (sq.size() == 0) begin
                    failures++;
                    $display("FAIL sw%0d unexpected_out sum=%h required no output", C, ssum);
                end else begin
                    if (!sseen) begin
                        sseen = 1'b1;
                        checks++;
                        if (cyc - sq[0].t != ST + 1) begin
                            failures++;
                            $display("FAIL sw%0d latency got=%0d required %0d",
                                     C, cyc - sq[0].t, ST + 1);
                        end
                    end
                    if (sordy) begin
                        se = sq.pop_front();
                        sseen = 1'b0;
                        checks++;
                        if (ssum !== se.s[3:0] || sco !== se.c || svf !== se.v) begin
                            failures++;
                            $display("FAIL sw%0d result sum=%h cout=%b ovf=%b required %h %b %b",
                                     C, ssum, sco, svf, se.s[3:0], se.c, se.v);
                        end
                    end
                end
            end
        end

        initial begin
            int n;
            sr = 1'b1;
            siv = 1'b1;
            sa = 4'h0;
            sb = 4'h0;
            ssub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            sr = 1'b0;
            for (int m = 0; m < 2; m++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        siv = 1'b1;
                        sa = 4'(x);
                        sb = 4'(y);
                        ssub = 1'(m);
                        n = 0;
                        @(negedge clk);
                        while (!sir && n < 50) begin
                            @(negedge clk);
                            n++;
                        end
                        checks++;
                        if (!sir) begin
                            failures++;
                            $display("FAIL sw%0d accept_timeout in_ready=%b required 1", C, sir);
                        end else begin
                            sq.push_back(mk(4, x, y, 1'(m), cyc));
                        end
                        @(posedge clk); #1;
                        siv = 1'b0;
                    end
                end
            end
            n = 0;
            while (sq.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (sq.size() != 0) begin
                failures++;
                $display("FAIL sw%0d drain pending=%0d required 0", C, sq.size());
            end
            sw_done++;
        end
    end

    initial begin
        wait (main_done && sw_done == 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog main_done=%0b sw_done=%0d required 1 3", main_done, sw_done);
        $fatal(1, "watchdog expired");
    end
endmodule
